// File: rtl/conv_out_bank_sched.sv
// conv_out_bank_sched: round-robin write steering into NUM_BANK FIFOs and in-order drain with aligned mux select.
// Optional drop detection ports under CONV_SCHED_OVF_DET_EN.
module conv_out_bank_sched #(
    parameter int NUM_BANK   = 8,
    parameter int BANK_DEPTH = 4096,
    parameter int BANK_IDX_W = 3,
    parameter int CNT_W      = 12,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [NUM_BANK-1:0]   bank_empty,
    input  logic                  out_ready,
    output logic [NUM_BANK-1:0]   bank_wr_en,
    output logic [NUM_BANK-1:0]   bank_rd_en,
    output logic [BANK_IDX_W-1:0] rd_sel,
    output logic                  valid_out,
    output logic                  frame_done
`ifdef CONV_SCHED_OVF_DET_EN
    ,
    output logic                  ovf_sticky,
    output logic [BANK_IDX_W-1:0] ovf_bank
`endif
);
    typedef enum logic {RD_WAIT, RD_RUN} state_t;
    localparam logic [CNT_W-1:0]      LAST = CNT_W'(BANK_DEPTH - 1);
    localparam logic [BANK_IDX_W-1:0] TOP  = BANK_IDX_W'(NUM_BANK - 1);

    state_t                       r_state, w_state_nxt;
    logic [BANK_IDX_W-1:0]        r_wr_bank, r_rd_bank, w_wr_bank_nxt, w_rd_bank_nxt;
    logic [CNT_W-1:0]             r_wr_cnt, r_rd_cnt;
    logic [NUM_BANK-1:0]          r_filled, w_filled_nxt;
    logic                         w_wr, w_rd, w_wr_last, w_rd_last, w_drop;
    logic [RD_LAT:0]              r_v, r_d;
    logic [RD_LAT:0][BANK_IDX_W-1:0] r_sel;

    always_comb begin
        w_wr          = valid_in & ~r_filled[r_wr_bank] & ~reset;
        w_drop        = valid_in & r_filled[r_wr_bank] & ~reset;
        w_rd          = (r_state == RD_RUN) & out_ready & ~bank_empty[r_rd_bank];
        w_wr_last     = w_wr & (r_wr_cnt == LAST);
        w_rd_last     = w_rd & (r_rd_cnt == LAST);
        w_wr_bank_nxt = (r_wr_bank == TOP) ? '0 : r_wr_bank + 1'b1;
        w_rd_bank_nxt = (r_rd_bank == TOP) ? '0 : r_rd_bank + 1'b1;
        // a bank finishing its fill this cycle is visible to the reader at once, so no wait bubble
        w_filled_nxt  = (r_filled | (NUM_BANK'(w_wr_last) << r_wr_bank)) & ~(NUM_BANK'(w_rd_last) << r_rd_bank);
        w_state_nxt   = (r_state == RD_WAIT) ? (w_filled_nxt[r_rd_bank] ? RD_RUN : RD_WAIT)
                      : ((w_rd_last && !w_filled_nxt[w_rd_bank_nxt]) ? RD_WAIT : RD_RUN);
        bank_wr_en    = NUM_BANK'(w_wr) << r_wr_bank;
        bank_rd_en    = NUM_BANK'(w_rd) << r_rd_bank;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= RD_WAIT;
            r_filled  <= '0;
            r_wr_bank <= '0;
            r_rd_bank <= '0;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_v       <= '0;
            r_d       <= '0;
            r_sel     <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_filled <= w_filled_nxt;
            if (w_wr) begin
                r_wr_cnt <= w_wr_last ? '0 : r_wr_cnt + 1'b1;
                if (w_wr_last) r_wr_bank <= w_wr_bank_nxt;
            end
            if (w_rd) begin
                r_rd_cnt <= w_rd_last ? '0 : r_rd_cnt + 1'b1;
                if (w_rd_last) r_rd_bank <= w_rd_bank_nxt;
            end
            // FIFO read latency plus the external output register
            r_v   <= {r_v[RD_LAT-1:0], w_rd};
            r_d   <= {r_d[RD_LAT-1:0], w_rd_last & (r_rd_bank == TOP)};
            r_sel <= {r_sel[RD_LAT-1:0], r_rd_bank};
        end
    end

    assign valid_out  = r_v[RD_LAT];
    assign frame_done = r_d[RD_LAT];
    assign rd_sel     = r_sel[RD_LAT];

`ifdef CONV_SCHED_OVF_DET_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_sticky <= 1'b0;
            ovf_bank   <= '0;
        end else if (w_drop && !ovf_sticky) begin
            ovf_sticky <= 1'b1;
            ovf_bank   <= r_wr_bank;
        end
    end
`endif
endmodule
